// File: rtl/multu_unit.sv
// multu_unit: 32-iteration shift-add unsigned multiplier with HI/LO.
// Sits beside the ALU; rd_data feeds the MFHI/MFLO result path.
module multu_unit #(
  parameter int unsigned WIDTH = 32,
  parameter logic [5:0] FUNCT_MULTU = 6'b011001,
  parameter logic [5:0] FUNCT_MFHI = 6'b010000,
  parameter logic [5:0] FUNCT_MFLO = 6'b010010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       funct,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_prod;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic          w_start;
  logic          w_load;
  logic          w_run;
  logic          w_last;
  logic [PW-1:0] w_addend;
  logic [PW-1:0] w_sum;
  logic          w_sel_hi;
  logic          w_sel_lo;

  assign w_start  = start && (funct == FUNCT_MULTU);
  assign w_load   = (r_state == S_IDLE) && w_start;
  assign w_run    = (r_state == S_RUN);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_addend = r_mplier[0] ? r_mcand : '0;
  // Top bits of mcand are zero at load, so the sum never overflows.
  assign w_sum    = r_prod + w_addend;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: start is only honoured from IDLE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_start) w_next = S_RUN;
      S_RUN:  if (w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from registered state only
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      S_RUN:  busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Shift-add datapath: load operands, then one iteration per RUN edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else begin
      unique case (1'b1)
        w_load: begin
          r_mcand  <= {{WIDTH{1'b0}}, dataA};
          r_mplier <= dataB;
          r_prod   <= '0;
          r_cnt    <= '0;
        end
        w_run: begin
          r_prod   <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // HI/LO take the final sum, including the last add, on the exit edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_run && w_last) begin
      r_hi <= w_sum[PW-1:WIDTH];
      r_lo <= w_sum[WIDTH-1:0];
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

  assign w_sel_hi = (funct == FUNCT_MFHI);
  assign w_sel_lo = (funct == FUNCT_MFLO);

  // MFHI/MFLO read port, zero for any other funct
  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      w_sel_hi: rd_data = r_hi;
      w_sel_lo: rd_data = r_lo;
      default:  rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_multu_unit.sv
// tb_multu_unit: directed vectors, scoreboard queue of products,
// monitor checks value and latency on every done pulse.
module tb_multu_unit;

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam int LAT = 32;

  logic        clk;
  logic        rst_n;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  funct;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  typedef struct {
    logic [63:0] p;
    int          due;
  } exp_t;

  exp_t q[$];
  int   nvec;
  int   nerr;
  int   cyc;

  multu_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dataA   (dataA),
    .dataB   (dataB),
    .funct   (funct),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: pop on each done, check product and cycle of arrival
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_done: got done=1 at cyc %0d want 0",
                   cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("product", {hi, lo}, e.p);
          chk("latency", 64'(cyc), 64'(e.due));
        end
      end else if (q.size() != 0 && cyc > q[0].due) begin
        nvec++;
        nerr++;
        $display("FAIL missing_done: got none by cyc %0d want cyc %0d",
                 cyc, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [5:0]  f,
                       input bit          acc,
                       input logic [63:0] p);
    exp_t e;
    dataA = a;
    dataB = b;
    funct = f;
    start = 1'b1;
    if (acc) begin
      e.p   = p;
      e.due = cyc + 1 + LAT;
      q.push_back(e);
    end
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && q.size() != 0; i++) tick(1);
    if (q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL wait_done: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    cyc   = 0;
    rst_n = 1'b0;
    dataA = '0;
    dataB = '0;
    funct = F_MFHI;
    start = 1'b0;
    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_rd", 64'(rd_data), 64'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // 3 x 5
    issue(32'd3, 32'd5, F_MULTU, 1'b1, 64'h0000000F);
    chk("busy_rise", 64'(busy), 64'd1);
    wait_done();
    tick(2);
    chk("idle_busy", 64'(busy), 64'd0);

    // Max operands and read port
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, F_MULTU, 1'b1,
          64'hFFFFFFFE_00000001);
    wait_done();
    tick(1);
    funct = F_MFHI;
    #1 chk("rd_mfhi", 64'(rd_data), 64'hFFFFFFFE);
    funct = F_MFLO;
    #1 chk("rd_mflo", 64'(rd_data), 64'h00000001);
    funct = F_ADD;
    #1 chk("rd_other", 64'(rd_data), 64'd0);

    // Non-MULTU start is ignored
    issue(32'd11, 32'd13, F_ADD, 1'b0, 64'd0);
    chk("add_busy", 64'(busy), 64'd0);
    tick(40);
    chk("add_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

    // 7 x 9 with a second start and operand churn mid-run
    issue(32'd7, 32'd9, F_MULTU, 1'b1, 64'd63);
    tick(4);
    issue(32'h10000, 32'h10000, F_MULTU, 1'b0, 64'd0);
    dataA = 32'hDEADBEEF;
    dataB = 32'h12345678;
    wait_done();
    tick(40);
    chk("busy_lo", 64'(lo), 64'd63);

    // Zero operand; HI/LO hold the old product during run
    issue(32'h12345678, 32'd0, F_MULTU, 1'b1, 64'd0);
    tick(10);
    funct = F_MFLO;
    #1 chk("hold_rd", 64'(rd_data), 64'd63);
    chk("hold_lo", 64'(lo), 64'd63);
    wait_done();
    tick(2);

    // Async reset mid-run aborts the multiply
    issue(32'h0000FFFF, 32'h0000FFFF, F_MULTU, 1'b1, 64'hFFFE0001);
    tick(9);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(40);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_hilo", {hi, lo}, 64'd0);

    issue(32'd2, 32'd2, F_MULTU, 1'b1, 64'd4);
    wait_done();
    tick(3);
    chk("q_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/multu_unit.md
Name: multu_unit

Overview:
- Multi-cycle unsigned multiplier for the MULTU function code (6'b011001).
- Sits beside the ALU output mux, which has no MULTU path of its own. It takes the same operand pair and funct field, runs a 32-iteration shift-add, and holds the 64-bit result in HI/LO.
- Provides an MFHI/MFLO read port whose output the datapath routes into the ALU result selection.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH bits.
- FUNCT_MULTU, 6'b011001, funct code that starts a multiply.
- FUNCT_MFHI, 6'b010000, funct code that selects HI on rd_data.
- FUNCT_MFLO, 6'b010010, funct code that selects LO on rd_data.

Ports:
- clk, input, 1, sole clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- dataA, input, WIDTH, multiplicand.
- dataB, input, WIDTH, multiplier.
- funct, input, 6, function code; the same field that drives the ALU mux select.
- start, input, 1, request strobe. Qualified by funct==FUNCT_MULTU.
- busy, output, 1, high while a multiply is in progress.
- done, output, 1, one-cycle pulse when HI/LO have just been updated.
- hi, output, WIDTH, upper half of the last completed product.
- lo, output, WIDTH, lower half of the last completed product.
- rd_data, output, WIDTH, combinational read port:
  - hi when funct==FUNCT_MFHI
  - lo when funct==FUNCT_MFLO
  - 0 otherwise

Behaviour:
- Reset (rst_n low, asynchronous, no clk needed): state=IDLE; busy=0, done=0, hi=0, lo=0; all internal registers 0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when start=1 and funct==FUNCT_MULTU at the rising edge. The load edge captures:
  - mcand = {WIDTH'b0, dataA} (2*WIDTH bits)
  - mplier = dataB
  - prod = 0
  - cnt = 0
- IDLE with start=1 and any other funct: ignored, no state change.
- RUN, each edge:
  - if mplier[0], prod = prod + mcand (2*WIDTH-bit add; cannot overflow)
  - mcand <<= 1; mplier >>= 1; cnt = cnt + 1
- RUN -> DONE on the edge that performs the iteration with cnt==WIDTH-1, i.e. the WIDTH-th RUN edge. On that same edge {hi,lo} is loaded with the final product, including that last addition.
- DONE -> IDLE on the next edge, unconditionally.
- Latency: start sampled at edge E0. done is high for exactly one cycle, between edges E0+WIDTH and E0+WIDTH+1. Fixed latency; no early termination on zero operands.
- busy=1 in RUN and DONE, 0 in IDLE. done=1 only in DONE. Both are decoded from registered state, so no combinational path from inputs.
- start while busy (RUN or DONE) is ignored: no restart, no queuing; the operands in flight are unaffected.
- Operands are sampled only on the load edge; changes to dataA/dataB during RUN have no effect.
- hi/lo hold their value until the next completion. They are not cleared at start, so a read during RUN returns the previous product.
- rd_data is purely combinational from funct, hi and lo. In the DONE cycle it already reflects the new product.
- rst_n asserted mid-RUN: the operation is aborted, all outputs go to reset values, and no done pulse is issued. After rst_n deasserts, the unit waits in IDLE for a new start.
- cnt width: $clog2(WIDTH) bits (5 for WIDTH=32); no wrap occurs because RUN exits at WIDTH-1.

Test Plan:
- Basic multiply: dataA=3, dataB=5, funct=011001, start for 1 cycle.
  - busy rises next cycle.
  - done pulses exactly 32 cycles after the start edge.
  - hi=0x00000000, lo=0x0000000F.
- Maximum operands: dataA=dataB=0xFFFFFFFF.
  - hi=0xFFFFFFFE, lo=0x00000001 after 32 cycles.
  - Then funct=010000 gives rd_data=0xFFFFFFFE; funct=010010 gives rd_data=0x00000001; funct=100000 gives rd_data=0.
- Filtering, not busy: start=1 with funct=100000 (ADD).
  - busy stays 0, no done, hi/lo unchanged.
- Filtering, busy: second MULTU start (0x10000 x 0x10000) issued 5 cycles into a 7x9 multiply.
  - Ignored; only one done pulse.
  - hi=0, lo=63.
  - Operand changes during RUN do not alter the result.
- Zero operand and hold: dataA=0x12345678, dataB=0, start.
  - done still arrives at 32 cycles; hi=lo=0.
  - Separately: after 7x9, start a new multiply; during its RUN, lo still reads 63 until the new done.
- Reset mid-operation: assert rst_n=0 asynchronously (between edges) at cycle 10 of a 0xFFFF x 0xFFFF multiply.
  - busy, done, hi, lo go to 0 immediately; no done pulse follows.
  - A fresh 2x2 multiply afterwards yields lo=4 with normal 32-cycle latency.
